// File: rtl/merge2to1_4bit.sv
// Two-into-one valid/ready merge with a single registered output word.
// Contention is resolved round-robin (RR=1) or with A as fixed winner (RR=0).
module merge2to1_4bit #(
  parameter int WIDTH = 4,
  parameter int RR    = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A_valid,
  input  logic [WIDTH-1:0] A,
  output logic             A_ready,
  input  logic             B_valid,
  input  logic [WIDTH-1:0] B,
  output logic             B_ready,
  output logic             X_valid,
  output logic [WIDTH-1:0] X,
  output logic             X_src,
  input  logic             X_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam bit RR_EN = (RR != 0);

  logic             x_valid_q, x_valid_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             x_src_q, x_src_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  logic load;
  logic gnt_b;
  logic xfer;

  always_comb begin
    load = ~x_valid_q | X_ready;
    // last_q = 1 means B won most recently, so the other side is favoured next.
    if (A_valid & B_valid) begin
      gnt_b = RR_EN ? ~last_q : 1'b0;
    end else begin
      gnt_b = B_valid;
    end
    xfer    = load & (A_valid | B_valid);
    A_ready = xfer & ~gnt_b;
    B_ready = xfer & gnt_b;
  end

  always_comb begin
    x_valid_d = x_valid_q;
    x_d       = x_q;
    x_src_d   = x_src_q;
    last_d    = last_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    if (xfer) begin
      x_valid_d = 1'b1;
      x_d       = gnt_b ? B : A;
      x_src_d   = gnt_b;
      last_d    = gnt_b;
      if (gnt_b) begin
        cnt_b_d = cnt_b_q + CNT_W'(1);
      end else begin
        cnt_a_d = cnt_a_q + CNT_W'(1);
      end
    end else if (X_ready) begin
      // Drained with nothing behind it: data and source are left as they were.
      x_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_valid_q <= 1'b0;
      x_q       <= '0;
      x_src_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
    end else begin
      x_valid_q <= x_valid_d;
      x_q       <= x_d;
      x_src_q   <= x_src_d;
      last_q    <= last_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
    end
  end

  assign X_valid = x_valid_q;
  assign X       = x_q;
  assign X_src   = x_src_q;
  assign cnt_a   = cnt_a_q;
  assign cnt_b   = cnt_b_q;

endmodule
